// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I/E decode stage with register file, control/imm decode,
// load-use stall FSM and ID/EX register. Optional macro ID_WB_BYPASS_EN: write-first regfile read.
module id_stage_pipe #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned LOAD_STALL = 1,
   parameter int unsigned CTRL_W     = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              if_valid,
   input  logic [XLEN-1:0]   if_pc,
   input  logic [XLEN-1:0]   if_pc4,
   input  logic [31:0]       if_instr,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_pc4,
   output logic [XLEN-1:0]   ex_data1,
   output logic [XLEN-1:0]   ex_data2,
   output logic [XLEN-1:0]   ex_imm,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic [31:0]       ex_instr
);
   localparam int unsigned NREGS = 1 << REG_AW;
   localparam int unsigned CNT_W = 2;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef struct packed {
      logic       branch;
      logic       mem_read;
      logic [2:0] mem_to_reg;
      logic [1:0] alu_op;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
      logic       jalr;
      logic       jump;
      logic       bne;
      logic       blt;
      logic       bge;
      logic       bltu;
      logic       bgeu;
   } ctrl_t;

   typedef enum logic {ST_RUN, ST_STALL} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [XLEN-1:0]   rf_q [NREGS];
   logic              ex_valid_q;
   ctrl_t             ex_ctrl_q;
   logic [XLEN-1:0]   ex_pc_q, ex_pc4_q, ex_data1_q, ex_data2_q, ex_imm_q;
   logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
   logic [31:0]       ex_instr_q;

   logic [6:0]        opcode_c;
   logic [2:0]        funct3_c;
   logic [REG_AW-1:0] rs1_c, rs2_c, rd_c;
   logic [31:0]       imm_i_c, imm_s_c, imm_b_c, imm_u_c, imm_j_c, imm32_c;
   logic [XLEN-1:0]   imm_c, rd1_c, rd2_c;
   ctrl_t             ctrl_c;
   logic              hazard_c, hold_c;

   assign opcode_c = if_instr[6:0];
   assign funct3_c = if_instr[14:12];
   assign rs1_c    = if_instr[15 +: REG_AW];
   assign rs2_c    = if_instr[20 +: REG_AW];
   assign rd_c     = if_instr[7 +: REG_AW];

   assign imm_i_c = {{20{if_instr[31]}}, if_instr[31:20]};
   assign imm_s_c = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
   assign imm_b_c = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
   assign imm_u_c = {if_instr[31:12], 12'b0};
   assign imm_j_c = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
   assign imm_c   = XLEN'($signed(imm32_c));

   // Control bundle and immediate format selection
   always_comb begin
      ctrl_c  = '0;
      imm32_c = '0;
      case (opcode_c)
         OP_IMM: begin
            ctrl_c.alu_op = 2'b11; ctrl_c.alu_src = 1'b1; ctrl_c.reg_write = 1'b1;
            imm32_c = imm_i_c;
         end
         OP_REG: begin
            ctrl_c.alu_op = 2'b10; ctrl_c.reg_write = 1'b1;
         end
         OP_LOAD: begin
            ctrl_c.mem_read = 1'b1; ctrl_c.mem_to_reg = 3'b001;
            ctrl_c.alu_src  = 1'b1; ctrl_c.reg_write  = 1'b1;
            imm32_c = imm_i_c;
         end
         OP_STORE: begin
            ctrl_c.mem_write = 1'b1; ctrl_c.alu_src = 1'b1;
            imm32_c = imm_s_c;
         end
         OP_BRANCH: begin
            ctrl_c.branch = 1'b1; ctrl_c.alu_op = 2'b01;
            imm32_c = imm_b_c;
            case (funct3_c)
               3'b001:  ctrl_c.bne  = 1'b1;
               3'b100:  ctrl_c.blt  = 1'b1;
               3'b101:  ctrl_c.bge  = 1'b1;
               3'b110:  ctrl_c.bltu = 1'b1;
               3'b111:  ctrl_c.bgeu = 1'b1;
               default: ;
            endcase
         end
         OP_JAL: begin
            ctrl_c.jump = 1'b1; ctrl_c.reg_write = 1'b1; ctrl_c.mem_to_reg = 3'b010;
            imm32_c = imm_j_c;
         end
         OP_JALR: begin
            ctrl_c.jalr = 1'b1; ctrl_c.alu_src = 1'b1; ctrl_c.reg_write = 1'b1;
            ctrl_c.mem_to_reg = 3'b010;
            imm32_c = imm_i_c;
         end
         OP_LUI: begin
            ctrl_c.alu_src = 1'b1; ctrl_c.reg_write = 1'b1; ctrl_c.mem_to_reg = 3'b011;
            imm32_c = imm_u_c;
         end
         OP_AUIPC: begin
            ctrl_c.alu_src = 1'b1; ctrl_c.reg_write = 1'b1; ctrl_c.mem_to_reg = 3'b100;
            imm32_c = imm_u_c;
         end
         default: ;
      endcase
   end

   // Register file read ports; x0 is hard-wired to zero
   always_comb begin
      rd1_c = (rs1_c == '0) ? '0 : rf_q[rs1_c];
      rd2_c = (rs2_c == '0) ? '0 : rf_q[rs2_c];
`ifdef ID_WB_BYPASS_EN
      if (wb_we && (wb_rd != '0) && (wb_rd == rs1_c)) rd1_c = wb_data;
      if (wb_we && (wb_rd != '0) && (wb_rd == rs2_c)) rd2_c = wb_data;
`endif
   end

   assign hazard_c = if_valid && ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != '0)
                     && ((ex_rd_q == rs1_c) || (ex_rd_q == rs2_c));
   assign hold_c     = !rst && !flush && ((state_q == ST_STALL) || hazard_c);
   assign pc_write   = !hold_c;
   assign ifid_write = !hold_c;

   // Stall FSM, ID/EX register and register file writes
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         cnt_q      <= '0;
         ex_valid_q <= 1'b0;
         ex_ctrl_q  <= '0;
         ex_pc_q    <= '0;
         ex_pc4_q   <= '0;
         ex_data1_q <= '0;
         ex_data2_q <= '0;
         ex_imm_q   <= '0;
         ex_rs1_q   <= '0;
         ex_rs2_q   <= '0;
         ex_rd_q    <= '0;
         ex_instr_q <= '0;
         for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
      end else begin
         if (wb_we && (wb_rd != '0)) rf_q[wb_rd] <= wb_data;
         if (flush) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            state_q    <= ST_RUN;
            cnt_q      <= '0;
         end else if (state_q == ST_STALL) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            cnt_q      <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= ST_RUN;
         end else if (hazard_c) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            if (LOAD_STALL > 1) begin
               state_q <= ST_STALL;
               cnt_q   <= CNT_W'(LOAD_STALL - 1);
            end
         end else if (if_valid) begin
            ex_valid_q <= 1'b1;
            ex_ctrl_q  <= ctrl_c;
            ex_pc_q    <= if_pc;
            ex_pc4_q   <= if_pc4;
            ex_data1_q <= rd1_c;
            ex_data2_q <= rd2_c;
            ex_imm_q   <= imm_c;
            ex_rs1_q   <= rs1_c;
            ex_rs2_q   <= rs2_c;
            ex_rd_q    <= rd_c;
            ex_instr_q <= if_instr;
         end else begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
         end
      end
   end

   assign ex_valid = ex_valid_q;
   assign ex_ctrl  = CTRL_W'(ex_ctrl_q);
   assign ex_pc    = ex_pc_q;
   assign ex_pc4   = ex_pc4_q;
   assign ex_data1 = ex_data1_q;
   assign ex_data2 = ex_data2_q;
   assign ex_imm   = ex_imm_q;
   assign ex_rs1   = ex_rs1_q;
   assign ex_rs2   = ex_rs2_q;
   assign ex_rd    = ex_rd_q;
   assign ex_instr = ex_instr_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed and random stimulus for id_stage_pipe against a transaction-level model.
module tb_id_stage_pipe;
   localparam int unsigned LS = 3;
   localparam int K_ADDI = 0, K_LW = 1, K_SW = 2, K_ADD = 3, K_BEQ = 4, K_BNE = 5, K_LUI = 6, K_JAL = 7;
   localparam logic [31:0] CTRL_MASK = 32'h000183B0;

   logic        clk = 1'b0;
   logic        rst, flush, if_valid, wb_we;
   logic [31:0] if_pc, if_pc4, if_instr, wb_data;
   logic [4:0]  wb_rd;
   logic        pc_write, ifid_write, ex_valid;
   logic [16:0] ex_ctrl;
   logic [31:0] ex_pc, ex_pc4, ex_data1, ex_data2, ex_imm, ex_instr;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;

   id_stage_pipe #(.XLEN(32), .REG_AW(5), .LOAD_STALL(LS), .CTRL_W(17)) dut (
      .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_pc(if_pc), .if_pc4(if_pc4),
      .if_instr(if_instr), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .pc_write(pc_write), .ifid_write(ifid_write), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
      .ex_pc(ex_pc), .ex_pc4(ex_pc4), .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_instr(ex_instr)
   );

   always #5 clk = ~clk;

   int n_pass = 0, n_fail = 0, n_total = 0;

   // Reference model state: what the EX slot should hold, in instruction terms
   logic [31:0] m_regs [32];
   logic        m_valid, m_imm_ok, last_pcw;
   int          m_kind, held_left, cur_kind, cur_imm;
   logic [31:0] m_pc, m_pc4, m_instr, m_imm, m_d1, m_d2;
   logic [4:0]  m_rd, m_rs1, m_rs2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc(input int k, input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input int imm);
      logic [31:0] v;
      v = 32'(imm);
      case (k)
         K_ADDI:  return {v[11:0], rs1, 3'b000, rd, 7'h13};
         K_LW:    return {v[11:0], rs1, 3'b010, rd, 7'h03};
         K_SW:    return {v[11:5], rs2, rs1, 3'b010, v[4:0], 7'h23};
         K_ADD:   return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
         K_BEQ:   return {v[12], v[10:5], rs2, rs1, 3'b000, v[4:1], v[11], 7'h63};
         K_BNE:   return {v[12], v[10:5], rs2, rs1, 3'b001, v[4:1], v[11], 7'h63};
         K_LUI:   return {v[31:12], rd, 7'h37};
         default: return {v[20], v[10:1], v[11], v[19:12], rd, 7'h6F};
      endcase
   endfunction

   function automatic logic [31:0] exp_ctrl(input int k);
      logic [31:0] c;
      c = '0;
      c[16] = (k == K_BEQ) || (k == K_BNE);
      c[15] = (k == K_LW);
      c[9]  = (k == K_SW);
      c[8]  = (k == K_ADDI) || (k == K_LW) || (k == K_SW) || (k == K_LUI);
      c[7]  = (k == K_ADDI) || (k == K_LW) || (k == K_ADD) || (k == K_LUI) || (k == K_JAL);
      c[5]  = (k == K_JAL);
      c[4]  = (k == K_BNE);
      return c;
   endfunction

   function automatic logic [31:0] mread(input logic [4:0] a);
      if (a == 5'd0) return '0;
`ifdef ID_WB_BYPASS_EN
      if (wb_we && (wb_rd == a)) return wb_data;
`endif
      return m_regs[a];
   endfunction

   task automatic set_instr(input int k, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input int imm);
      cur_kind = k;
      cur_imm  = imm;
      if_instr = enc(k, rd, rs1, rs2, imm);
   endtask

   task automatic rand_instr();
      int k, imm;
      k = int'($urandom_range(0, 7));
      case (k)
         K_ADDI, K_LW, K_SW: imm = int'($urandom_range(0, 4095)) - 2048;
         K_BEQ, K_BNE:       imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
         K_LUI:              imm = int'($urandom & 32'hFFFFF000);
         K_JAL:              imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
         default:            imm = 0;
      endcase
      set_instr(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), imm);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_valid = 1'b0; m_kind = K_ADD; held_left = 0; m_imm_ok = 1'b1;
      m_pc = '0; m_pc4 = '0; m_instr = '0; m_imm = '0; m_d1 = '0; m_d2 = '0;
      m_rd = '0; m_rs1 = '0; m_rs2 = '0;
   endtask

   // One clock: check stall enables before the edge, then the EX slot after it
   task automatic tick();
      logic [4:0]  f1, f2;
      logic [31:0] d1, d2;
      logic        hz, exp_pcw;
      f1 = if_instr[19:15];
      f2 = if_instr[24:20];
      hz = if_valid && m_valid && (m_kind == K_LW) && (m_rd != 5'd0) && ((m_rd == f1) || (m_rd == f2));
      exp_pcw = rst || flush || !((held_left > 0) || hz);
      last_pcw = exp_pcw;
      #1;
      if (!rst) begin
         chk("pc_write", 32'(pc_write), 32'(exp_pcw));
         chk("ifid_write", 32'(ifid_write), 32'(exp_pcw));
      end
      d1 = mread(f1);
      d2 = mread(f2);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (wb_we && (wb_rd != 5'd0)) m_regs[wb_rd] = wb_data;
         if (flush) begin
            m_valid = 1'b0; held_left = 0;
         end else if (held_left > 0) begin
            m_valid = 1'b0; held_left--;
         end else if (hz) begin
            m_valid = 1'b0; held_left = int'(LS) - 1;
         end else if (if_valid) begin
            m_valid = 1'b1; m_kind = cur_kind; m_pc = if_pc; m_pc4 = if_pc4; m_instr = if_instr;
            m_rd = if_instr[11:7]; m_rs1 = f1; m_rs2 = f2; m_d1 = d1; m_d2 = d2;
            m_imm = 32'(cur_imm); m_imm_ok = (cur_kind != K_ADD);
         end else begin
            m_valid = 1'b0;
         end
      end
      #1;
      chk("ex_valid", 32'(ex_valid), 32'(m_valid));
      if (m_valid) chk("ex_ctrl", 32'(ex_ctrl) & CTRL_MASK, exp_ctrl(m_kind));
      else         chk("ex_ctrl_bubble", 32'(ex_ctrl), 32'd0);
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_pc4", ex_pc4, m_pc4);
      chk("ex_instr", ex_instr, m_instr);
      chk("ex_rs1", 32'(ex_rs1), 32'(m_rs1));
      chk("ex_rs2", 32'(ex_rs2), 32'(m_rs2));
      chk("ex_rd", 32'(ex_rd), 32'(m_rd));
      chk("ex_data1", ex_data1, m_d1);
      chk("ex_data2", ex_data2, m_d2);
      if (m_imm_ok) chk("ex_imm", ex_imm, m_imm);
   endtask

   initial begin
      int held, bubbles;
      rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_pc4 = '0; if_instr = '0;
      wb_we = 1'b0; wb_rd = '0; wb_data = '0; cur_kind = K_ADD; cur_imm = 0; last_pcw = 1'b1;
      model_reset();

      // Reset for two cycles
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("t1_ex_valid", 32'(ex_valid), 32'd0);
      chk("t1_ex_ctrl", 32'(ex_ctrl), 32'd0);
      chk("t1_ex_pc", ex_pc, 32'd0);
      chk("t1_pc_write", 32'(pc_write), 32'd1);
      chk("t1_ifid_write", 32'(ifid_write), 32'd1);

      // addi x1,x0,5 at 0x10
      if_valid = 1'b1; if_pc = 32'h10; if_pc4 = 32'h14;
      set_instr(K_ADDI, 5'd1, 5'd0, 5'd0, 5);
      tick();
      chk("t2_instr_enc", ex_instr, 32'h00500093);
      chk("t2_ex_valid", 32'(ex_valid), 32'd1);
      chk("t2_ex_rd", 32'(ex_rd), 32'd1);
      chk("t2_ex_imm", ex_imm, 32'd5);
      chk("t2_ex_pc", ex_pc, 32'h10);
      chk("t2_regwrite", 32'(ex_ctrl[7]), 32'd1);
      chk("t2_alusrc", 32'(ex_ctrl[8]), 32'd1);
      chk("t2_memread", 32'(ex_ctrl[15]), 32'd0);

      // lw x2,0(x1) followed by dependent add x3,x2,x2
      if_pc = 32'h14; if_pc4 = 32'h18;
      set_instr(K_LW, 5'd2, 5'd1, 5'd0, 0);
      tick();
      chk("t3_lw_enc", ex_instr, 32'h0000A103);
      chk("t3_lw_memread", 32'(ex_ctrl[15]), 32'd1);
      if_pc = 32'h18; if_pc4 = 32'h1C;
      set_instr(K_ADD, 5'd3, 5'd2, 5'd2, 0);
      held = 0; bubbles = 0;
      for (int i = 0; i < int'(LS) + 2; i++) begin
         #1;
         if (pc_write !== 1'b0) break;
         held++;
         tick();
         if (ex_valid === 1'b0) bubbles++;
      end
      chk("t3_held_cycles", 32'(held), 32'(LS));
      chk("t3_bubbles", 32'(bubbles), 32'(LS));
      tick();
      chk("t3_add_valid", 32'(ex_valid), 32'd1);
      chk("t3_add_instr", ex_instr, 32'h002101B3);

      // Load-use hazard coinciding with flush
      if_pc = 32'h1C; if_pc4 = 32'h20;
      set_instr(K_LW, 5'd2, 5'd1, 5'd0, 0);
      tick();
      set_instr(K_ADD, 5'd3, 5'd2, 5'd2, 0);
      flush = 1'b1;
      #1;
      chk("t4_pc_write_flush", 32'(pc_write), 32'd1);
      tick();
      chk("t4_ex_valid", 32'(ex_valid), 32'd0);
      flush = 1'b0;
      if_pc = 32'h40; if_pc4 = 32'h44;
      set_instr(K_ADDI, 5'd5, 5'd0, 5'd0, 1);
      #1;
      chk("t4_no_stall", 32'(pc_write), 32'd1);
      tick();
      chk("t4_issue", 32'(ex_valid), 32'd1);

      // Writes to x0 are dropped; same-cycle read of a written register
      wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
      tick();
      wb_we = 1'b0;
      set_instr(K_ADD, 5'd6, 5'd0, 5'd0, 0);
      tick();
      chk("t5_x0_rs1", ex_data1, 32'd0);
      chk("t5_x0_rs2", ex_data2, 32'd0);
      wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
      set_instr(K_ADDI, 5'd7, 5'd3, 5'd0, 0);
      tick();
`ifdef ID_WB_BYPASS_EN
      chk("t5_same_cycle", ex_data1, 32'hDEADBEEF);
`else
      chk("t5_same_cycle", ex_data1, 32'd0);
`endif
      wb_we = 1'b0;
      tick();
      chk("t5_after_write", ex_data1, 32'hDEADBEEF);

      // Reset while stalled
      set_instr(K_LW, 5'd2, 5'd1, 5'd0, 0);
      tick();
      set_instr(K_ADD, 5'd3, 5'd2, 5'd2, 0);
      tick();
      #1;
      chk("t6_in_stall", 32'(pc_write), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_ex_valid", 32'(ex_valid), 32'd0);
      #1;
      chk("t6_pc_write", 32'(pc_write), 32'd1);
      tick();
      chk("t6_issue", 32'(ex_valid), 32'd1);

      // Random traffic; IF holds its instruction whenever pc_write was low
      for (int c = 0; c < 500; c++) begin
         if (last_pcw) begin
            rand_instr();
            if_valid = ($urandom_range(0, 7) != 0);
            if_pc    = $urandom & 32'hFFFFFFFC;
            if_pc4   = if_pc + 32'd4;
         end
         flush   = ($urandom_range(0, 9) == 0);
         rst     = ($urandom_range(0, 99) == 0);
         wb_we   = 1'($urandom_range(0, 1));
         wb_rd   = 5'($urandom_range(0, 7));
         wb_data = $urandom;
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
